// File: rtl/term_config_chain_pkg.sv
// Shared types and sizing helpers for the termination-tile
// configuration chain.
package term_cfg_pkg;

  typedef enum logic [1:0] {
    OPER,
    SHIFT,
    COMMIT
  } cfg_state_t;

  function automatic int num_frames(int n, int fb);
    return (n + fb - 1) / fb;
  endfunction

  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/term_config_chain_if.sv
// Configuration bus of a termination tile: serial chain,
// frame port and the committed configuration outputs.
interface term_config_chain_if #(
  parameter int NoConfigBits    = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32
);

  logic                       MODE;
  logic                       CONFin;
  logic                       CONFout;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic [MaxFramesPerCol-1:0] FrameStrobe_O;
  logic [NoConfigBits-1:0]    ConfigBits;
  logic [NoConfigBits-1:0]    ConfigBits_N;
  logic                       ConfigDone;
  logic                       ConfigErr;

  modport master (
    output MODE, CONFin,
    output FrameData, FrameStrobe,
    input  CONFout, FrameStrobe_O,
    input  ConfigBits, ConfigBits_N,
    input  ConfigDone, ConfigErr
  );

  modport slave (
    input  MODE, CONFin,
    input  FrameData, FrameStrobe,
    output CONFout, FrameStrobe_O,
    output ConfigBits, ConfigBits_N,
    output ConfigDone, ConfigErr
  );

endinterface

// File: rtl/term_config_chain_shift.sv
// Serial shadow register with saturating bit counter and a
// one-cycle CONFout stage toward the downstream tile.
module term_cfg_shift
  import term_cfg_pkg::*;
#(
  parameter int NoConfigBits = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    confin,
  output logic [NoConfigBits-1:0] shadow,
  output logic                    full,
  output logic                    confout
);

  localparam int CW = cnt_width(NoConfigBits);
  localparam logic [CW-1:0] CMAX = CW'(NoConfigBits);

  logic [CW-1:0]           cnt;
  logic [NoConfigBits-1:0] shadow_nxt;

  if (NoConfigBits == 1) begin : g_one
    assign shadow_nxt = confin;
  end else begin : g_many
    assign shadow_nxt = {shadow[NoConfigBits-2:0], confin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      cnt     <= '0;
      confout <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      shadow  <= shadow_nxt;
      confout <= shadow[NoConfigBits-1];
      if (cnt != CMAX)
        cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == CMAX);

endmodule

// File: rtl/term_config_chain.sv
// Termination-tile configuration store: serial chain with
// commit-on-exit, frame writes and a strobe repeater.
module term_config_chain
  import term_cfg_pkg::*;
#(
  parameter int NoConfigBits    = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter bit StrobeRepeat    = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  term_config_chain_if.slave bus
);

  localparam int NF = num_frames(NoConfigBits, FrameBitsPerRow);

  cfg_state_t              state;
  logic [NoConfigBits-1:0] shadow;
  logic [NoConfigBits-1:0] cfg;
  logic [NoConfigBits-1:0] cfg_nxt;
  logic [NoConfigBits-1:0] wr_en;
  logic [NoConfigBits-1:0] wr_data;
  logic                    full;
  logic                    confout;
  logic                    commit;
  logic                    done;
  logic                    err;

  term_cfg_shift #(
    .NoConfigBits(NoConfigBits)
  ) u_shift (
    .clk    (CLK),
    .rst    (RST),
    .clear  (state != SHIFT && bus.MODE),
    .en     (state == SHIFT),
    .confin (bus.CONFin),
    .shadow (shadow),
    .full   (full),
    .confout(confout)
  );

  // Map every config bit to its frame strobe and data lane
  for (genvar b = 0; b < NoConfigBits; b++) begin : g_bit
    localparam int FI = b / FrameBitsPerRow;
    localparam int DI = b % FrameBitsPerRow;
    if (FI < NF && FI < MaxFramesPerCol) begin : g_on
      assign wr_en[b] = bus.FrameStrobe[FI];
    end else begin : g_off
      assign wr_en[b] = 1'b0;
    end
    assign wr_data[b] = bus.FrameData[DI];
  end

  assign commit = (state == COMMIT) && full;

  // Frame data lands after the commit so it wins on overlap
  always_comb begin
    cfg_nxt = cfg;
    if (commit)
      cfg_nxt = shadow;
    cfg_nxt = (cfg_nxt & ~wr_en) | (wr_data & wr_en);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cfg <= '0;
    else
      cfg <= cfg_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= OPER;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        OPER: begin
          if (bus.MODE) begin
            state <= SHIFT;
            err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (!bus.MODE)
            state <= COMMIT;
        end
        COMMIT: begin
          done <= full;
          if (!full)
            err <= 1'b1;
          else if (bus.MODE)
            err <= 1'b0;
          state <= bus.MODE ? SHIFT : OPER;
        end
        default: state <= OPER;
      endcase
    end
  end

  if (StrobeRepeat) begin : g_rep
    logic [MaxFramesPerCol-1:0] strobe_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)
        strobe_q <= '0;
      else
        strobe_q <= bus.FrameStrobe;
    end
    assign bus.FrameStrobe_O = strobe_q;
  end else begin : g_wire
    assign bus.FrameStrobe_O = bus.FrameStrobe;
  end

  assign bus.ConfigBits   = cfg;
  assign bus.ConfigBits_N = ~cfg;
  assign bus.ConfigDone   = done;
  assign bus.ConfigErr    = err;
  assign bus.CONFout      = confout;

endmodule

// File: doc/term_config_chain.md
Name: term_config_chain

Overview:
- Parametrised configuration-storage block for fabric termination tiles (N/S/E/W term variants), generalising the fixed, config-less terminal tile.
- Holds NoConfigBits of switch-matrix configuration, loadable two ways: the serial CONFin/CONFout daisy chain while MODE=1, or frame-based writes via FrameStrobe/FrameData.
- Adds a registered FrameStrobe repeater, commit-on-exit semantics, underflow error detection and a done pulse.

Parameters:
- NoConfigBits, 32, configuration bits held by this tile (>=1).
- MaxFramesPerCol, 20, FrameStrobe width.
- FrameBitsPerRow, 32, FrameData width.
- StrobeRepeat, 1, 1 = FrameStrobe_O registered one stage; 0 = combinational pass-through.

Ports:
- CLK  in  1  configuration/operation clock.
- RST  in  1  asynchronous active-high reset.
- MODE  in  1  global mode: 1 = configuration, 0 = operation.
- CONFin  in  1  serial config data from upstream tile.
- CONFout  out  1  serial config data to downstream tile.
- FrameData  in  FrameBitsPerRow  frame write data.
- FrameStrobe  in  MaxFramesPerCol  one-hot frame write strobes.
- FrameStrobe_O  out  MaxFramesPerCol  strobes to next tile in column.
- ConfigBits  out  NoConfigBits  committed configuration to the switch matrix.
- ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits.
- ConfigDone  out  1  one-cycle pulse on successful serial commit.
- ConfigErr  out  1  sticky serial underflow error.

Behaviour:
- Reset (async, RST=1): state OPER; shadow, ConfigBits, bit counter, CONFout, FrameStrobe_O, ConfigDone and ConfigErr all 0. ConfigBits_N = all 1s.
- FSM states: OPER, SHIFT, COMMIT.
  - OPER -> SHIFT when MODE=1. Entering SHIFT clears the counter and ConfigErr.
  - SHIFT: each CLK, shadow <= {shadow[NoConfigBits-2:0], CONFin}. CONFout <= old shadow MSB, giving one cycle of latency per tile. Counter increments and saturates at NoConfigBits.
  - If NoConfigBits=1, shadow <= CONFin.
  - Extra bits beyond NoConfigBits are normal and pass through to downstream tiles. The shadow keeps the last NoConfigBits bits received.
  - SHIFT -> COMMIT when MODE=0.
  - COMMIT, counter==NoConfigBits: ConfigBits <= shadow and ConfigDone=1 for that cycle.
  - COMMIT, counter<NoConfigBits: ConfigBits unchanged, ConfigErr <= 1 (sticky until next SHIFT entry or reset).
  - COMMIT -> OPER unconditionally, or -> SHIFT if MODE=1 again. On the direct COMMIT->SHIFT path the commit still occurs.
- Frame writes, active in any state:
  - Frame i covers ConfigBits[i*FrameBitsPerRow +: FrameBitsPerRow].
  - NumFrames = ceil(NoConfigBits/FrameBitsPerRow). Strobes with index >= NumFrames are ignored.
  - For a partial last frame, the upper FrameData bits are ignored.
  - Each asserted strobe writes FrameData into its slice on the next CLK. Multiple strobes in one cycle are legal and all write the same data.
  - Frame writes do not touch the shadow, counter, ConfigDone or ConfigErr.
- Same-cycle COMMIT and frame write: the commit applies first, then the frame slice overrides it. Frame data wins on overlapping bits.
- ConfigBits_N is combinational ~ConfigBits.
- FrameStrobe_O: with StrobeRepeat=1, a 1-cycle registered copy of FrameStrobe; with StrobeRepeat=0, a wire.
- Reset mid-SHIFT: everything returns to reset values, with no partial commit.
- MODE glitch of exactly one SHIFT cycle: counter=1, so COMMIT takes the underflow branch and raises ConfigErr (when NoConfigBits>1).
- Counter width: $clog2(NoConfigBits+1).

Decomposition:
- Package term_cfg_pkg holds:
  - state enum cfg_state_t {OPER, SHIFT, COMMIT};
  - localparam function num_frames(NoConfigBits, FrameBitsPerRow);
  - counter-width helper.
- Sub-module term_cfg_shift: shadow register, saturating bit counter and CONFout flop, with outputs shadow, full and CONFout.
- term_config_chain holds the FSM, the ConfigBits register with frame-write merge, the strobe repeater and the flags.

Test Plan (NoConfigBits=8, FrameBitsPerRow=4, MaxFramesPerCol=4, StrobeRepeat=1):
- Reset with RST pulsed mid-cycle -> ConfigBits=0x00, ConfigBits_N=0xFF, ConfigErr=0, FrameStrobe_O=0 immediately (asynchronous).
- MODE=1, shift 0xA5 MSB-first over 8 CLKs, MODE=0 -> ConfigBits=0xA5, one-cycle ConfigDone; CONFout sequence equals the prior shadow contents (0x00) delayed 1 cycle.
- Shift 12 bits 0xF3C MSB-first, then MODE=0 -> ConfigBits=0x3C; first 4 bits (0xF) appear on CONFout 8 cycles later than they were shifted in.
- Shift only 5 bits, then MODE=0 -> ConfigBits holds its old value, ConfigErr=1 and stays 1; next MODE=1 clears it.
- In OPER: FrameStrobe=0b0010 with FrameData=0x9, then FrameStrobe=0b0100 with FrameData=0x7 -> ConfigBits[7:4]=0x9; strobe 2 is ignored; FrameStrobe_O mirrors each strobe 1 cycle later.
- COMMIT of 0xA5 coinciding with FrameStrobe=0b0001, FrameData=0x0 -> ConfigBits=0xA0, ConfigDone=1.
